bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
Multi-digit packed-BCD down-counter/timer, the counting-down counterpart to the team's BCD up-counters. It is loaded with a decimal preset, decrements once per tick enable while running, and flags expiry with a one-cycle `done` pulse. It supports one-shot and auto-reload modes and is used for decimal timeouts and display countdowns.

Parameters:
- DIGITS, 4, number of BCD digits. count width = 4*DIGITS.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- load  in  1  load preset from load_val. Pulse.
- load_val  in  4*DIGITS  packed BCD preset. Digit 0 is in [3:0].
- start  in  1  begin or resume counting. Pulse.
- stop  in  1  pause counting. Pulse.
- auto_reload  in  1  1 = reload on expiry, 0 = one-shot. Sampled at the expiry tick.
- tick  in  1  count enable. One decrement per cycle while high in RUN.
- count  out  4*DIGITS  current packed BCD value.
- running  out  1  high while in state RUN.
- expired  out  1  high while in state EXPIRED.
- done  out  1  one-cycle pulse on expiry.
- load_err  out  1  sticky flag: rejected non-BCD preset.

Behaviour:
- Reset values: count=0, reload_reg=0, state=IDLE, done=0, load_err=0.
- rst has priority over every other input. Reset mid-RUN returns all of the above to reset values at that clock edge.
- All outputs are registered. There is no combinational path from input to output.
- States: IDLE, RUN, EXPIRED.
- Per-cycle priority: rst > load > stop > start > tick.
- load, valid case (every digit of load_val ≤ 9):
  - count ← load_val and reload_reg ← load_val.
  - load_err ← 0; state ← IDLE.
  - start, stop and tick in the same cycle are ignored.
- load, invalid case (any digit of load_val ≥ 0xA):
  - count, reload_reg and state are unchanged.
  - load_err ← 1, held until the next valid load or rst.
- stop:
  - In RUN: state ← IDLE, count held.
  - In any other state: no effect.
  - stop with tick in the same cycle: no decrement.
- start:
  - IDLE with count ≠ 0: state ← RUN. Takes effect from the next cycle; a tick in the same cycle is ignored.
  - IDLE with count == 0: stays IDLE, no done.
  - EXPIRED with reload_reg ≠ 0: count ← reload_reg, state ← RUN.
  - EXPIRED with reload_reg == 0: stays EXPIRED.
  - start while already in RUN: no effect.
- tick in RUN, normal decrement:
  - Packed-BCD decrement by 1.
  - Each digit: d−1 if d > 0, else 9 with borrow to the next digit.
  - Borrow out of the top digit cannot occur, because RUN never decrements from 0.
- tick in RUN with count == 1 (expiry):
  - done ← 1 for exactly one cycle, registered alongside the count update.
  - auto_reload = 0: count ← 0, state ← EXPIRED.
  - auto_reload = 1: count ← reload_reg, state stays RUN. Count never shows 0, so the period is exactly reload_reg ticks.
- tick outside RUN is ignored.
- done is 0 in every cycle except the expiry cycle.
- Latency: start→running is 1 cycle; tick→count update is 1 cycle.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W = 4 and BCD_MAX = 9;
  - timer state enum {IDLE, RUN, EXPIRED};
  - function is_valid_bcd(digit).
- Sub-module bcd_digit_dec: one digit, with inputs d[3:0] and borrow_in, outputs q[3:0] and borrow_out.
  - borrow_in = 0: q = d, borrow_out = 0.
  - borrow_in = 1: q = d−1 (or 9 when d = 0); borrow_out = 1 only when d = 0.
  - Instantiated DIGITS times by generate, chained from digit 0, with digit 0 borrow_in = 1.
- Top level holds the FSM, reload_reg, load validation and output registers.

Test Plan (DIGITS=4):
1. load 0x0003, start, tick held high → count 0003, 0002, 0001, 0000 on successive cycles. done=1 only in the 0000 cycle, then expired=1 and running=0.
2. load 0x1000, start, one tick → count 0x0999. Repeat with 0x0100 → 0x0099, checking the borrow chain.
3. auto_reload=1, load 0x0002, start, continuous tick → count 2, 1, 2, 1, … with done pulsing every 2 ticks (each 1→2 transition) and running=1 throughout.
4. load 0x00A5 → load_err=1, count unchanged. Then load 0x0042 → load_err=0, count=0x0042.
5. Running at 0x0005: assert stop and tick together → count stays 0x0005, state IDLE. Load 0x0000 then start → stays IDLE, no done. Assert start and load together → load wins, state IDLE.
6. Running at 0x0050, assert rst for one cycle → next edge count=0, running=0, expired=0, done=0, load_err=0. Subsequent start is ignored because count == 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, timer state encoding and digit validity check
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    function automatic logic is_valid_bcd(input logic [BCD_DIGIT_W-1:0] digit);
        return digit <= BCD_DIGIT_W'(BCD_MAX);
    endfunction
endpackage

// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: control and status bundle of the BCD down-timer
interface bcd_down_timer_if #(parameter int DIGITS = 4);
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic                start;
    logic                stop;
    logic                auto_reload;
    logic                tick;
    logic [4*DIGITS-1:0] count;
    logic                running;
    logic                expired;
    logic                done;
    logic                load_err;
    modport master (output load, load_val, start, stop, auto_reload, tick,
                    input  count, running, expired, done, load_err);
    modport slave  (input  load, load_val, start, stop, auto_reload, tick,
                    output count, running, expired, done, load_err);
endinterface

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: single BCD digit decrement stage with borrow chaining
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    input  logic                   borrow_in,
    output logic [BCD_DIGIT_W-1:0] q,
    output logic                   borrow_out
);
    assign borrow_out = borrow_in && d == '0;
    assign q = !borrow_in ? d : (d == '0 ? BCD_DIGIT_W'(BCD_MAX) : d - BCD_DIGIT_W'(1));
endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: packed-BCD down-counter with one-shot/auto-reload expiry
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_down_timer_if.slave   bus
);
    localparam int W = BCD_DIGIT_W * DIGITS;
    state_t         state, state_nx;
    logic [W-1:0]   count_q, count_nx, reload_q, reload_nx, count_dec;
    logic           done_q, done_nx, err_q, err_nx;
    logic [DIGITS:0]   bw;
    logic [DIGITS-1:0] dig_ok;
    logic           borrow_unused;
    logic           valid;
    assign bw[0] = 1'b1;
    assign borrow_unused = bw[DIGITS];
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_dec u_dec (
            .d          (count_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .borrow_in  (bw[i]),
            .q          (count_dec[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .borrow_out (bw[i+1])
        );
        assign dig_ok[i] = is_valid_bcd(bus.load_val[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
    assign valid = &dig_ok;
    // next-state decode, priority load > stop > start > tick
    always_comb begin
        state_nx  = state;
        count_nx  = count_q;
        reload_nx = reload_q;
        done_nx   = 1'b0;
        err_nx    = err_q;
        if (bus.load) begin
            if (valid) begin
                count_nx  = bus.load_val;
                reload_nx = bus.load_val;
                err_nx    = 1'b0;
                state_nx  = IDLE;
            end else begin
                err_nx = 1'b1;
            end
        end else if (bus.stop) begin
            state_nx = state == RUN ? IDLE : state;
        end else if (bus.start) begin
            if (state == IDLE && count_q != '0) begin
                state_nx = RUN;
            end else if (state == EXPIRED && reload_q != '0) begin
                count_nx = reload_q;
                state_nx = RUN;
            end
        end else if (bus.tick && state == RUN) begin
            if (count_q == W'(1)) begin
                done_nx  = 1'b1;
                count_nx = bus.auto_reload ? reload_q : '0;
                state_nx = bus.auto_reload ? RUN : EXPIRED;
            end else begin
                count_nx = count_dec;
            end
        end
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            count_q  <= count_nx;
            reload_q <= reload_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
        end
    end
    assign bus.count    = count_q;
    assign bus.running  = state == RUN;
    assign bus.expired  = state == EXPIRED;
    assign bus.done     = done_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed scoreboard bench for the BCD down-timer
module tb_bcd_down_timer;
    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    bcd_down_timer_if #(.DIGITS(4)) bus ();
    bcd_down_timer #(.DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic l, input logic [15:0] lv,
                        input logic st, input logic sp, input logic ar, input logic tk,
                        input logic [15:0] ec, input logic er, input logic ex,
                        input logic ed, input logic ee);
        exp_t e;
        logic [19:0] got;
        @(negedge clk);
        rst = r;
        bus.load = l;
        bus.load_val = lv;
        bus.start = st;
        bus.stop = sp;
        bus.auto_reload = ar;
        bus.tick = tk;
        sb.push_back('{tag, {ec, er, ex, ed, ee}});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got = {bus.count, bus.running, bus.expired, bus.done, bus.load_err};
        n_chk++;
        assert (got === e.v) n_pass++;
        else $error("FAIL %s: got count=%h run/exp/done/err=%b, required count=%h run/exp/done/err=%b",
                    e.tag, got[19:4], got[3:0], e.v[19:4], e.v[3:0]);
    endtask

    initial begin
        bus.load = 0; bus.load_val = 0; bus.start = 0; bus.stop = 0;
        bus.auto_reload = 0; bus.tick = 0;
        //    tag           rst ld val     st sp ar tk  count   run exp done err
        step("reset0",      1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        step("reset1",      1, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
        step("t1_load",     0, 1, 16'h0003, 0, 0, 0, 0, 16'h0003, 0, 0, 0, 0);
        step("t1_start",    0, 0, 16'h0000, 1, 0, 0, 1, 16'h0003, 1, 0, 0, 0);
        step("t1_tick2",    0, 0, 16'h0000, 0, 0, 0, 1, 16'h0002, 1, 0, 0, 0);
        step("t1_tick1",    0, 0, 16'h0000, 0, 0, 0, 1, 16'h0001, 1, 0, 0, 0);
        step("t1_expire",   0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 1, 1, 0);
        step("t1_hold",     0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 1, 0, 0);
        step("t1_restart",  0, 0, 16'h0000, 1, 0, 0, 0, 16'h0003, 1, 0, 0, 0);
        step("t1_stop",     0, 0, 16'h0000, 0, 1, 0, 0, 16'h0003, 0, 0, 0, 0);
        step("t2_load1000", 0, 1, 16'h1000, 0, 0, 0, 0, 16'h1000, 0, 0, 0, 0);
        step("t2_start",    0, 0, 16'h0000, 1, 0, 0, 0, 16'h1000, 1, 0, 0, 0);
        step("t2_borrow3",  0, 0, 16'h0000, 0, 0, 0, 1, 16'h0999, 1, 0, 0, 0);
        step("t2_stop",     0, 0, 16'h0000, 0, 1, 0, 0, 16'h0999, 0, 0, 0, 0);
        step("t2_load0100", 0, 1, 16'h0100, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0);
        step("t2_start2",   0, 0, 16'h0000, 1, 0, 0, 0, 16'h0100, 1, 0, 0, 0);
        step("t2_borrow2",  0, 0, 16'h0000, 0, 0, 0, 1, 16'h0099, 1, 0, 0, 0);
        step("t2_stop2",    0, 0, 16'h0000, 0, 1, 0, 0, 16'h0099, 0, 0, 0, 0);
        step("t3_load",     0, 1, 16'h0002, 0, 0, 1, 0, 16'h0002, 0, 0, 0, 0);
        step("t3_start",    0, 0, 16'h0000, 1, 0, 1, 0, 16'h0002, 1, 0, 0, 0);
        step("t3_tick1",    0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 1, 0, 0, 0);
        step("t3_reload1",  0, 0, 16'h0000, 0, 0, 1, 1, 16'h0002, 1, 0, 1, 0);
        step("t3_tick1b",   0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 1, 0, 0, 0);
        step("t3_reload2",  0, 0, 16'h0000, 0, 0, 1, 1, 16'h0002, 1, 0, 1, 0);
        step("t3_stop",     0, 0, 16'h0000, 0, 1, 0, 1, 16'h0002, 0, 0, 0, 0);
        step("t4_bad",      0, 1, 16'h00A5, 0, 0, 0, 0, 16'h0002, 0, 0, 0, 1);
        step("t4_sticky",   0, 0, 16'h0000, 0, 0, 0, 1, 16'h0002, 0, 0, 0, 1);
        step("t4_good",     0, 1, 16'h0042, 0, 0, 0, 0, 16'h0042, 0, 0, 0, 0);
        step("t5_load5",    0, 1, 16'h0005, 0, 0, 0, 0, 16'h0005, 0, 0, 0, 0);
        step("t5_start",    0, 0, 16'h0000, 1, 0, 0, 1, 16'h0005, 1, 0, 0, 0);
        step("t5_start_run",0, 0, 16'h0000, 1, 0, 0, 0, 16'h0005, 1, 0, 0, 0);
        step("t5_stoptick", 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0005, 0, 0, 0, 0);
        step("t5_idletick", 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0005, 0, 0, 0, 0);
        step("t5_load0",    0, 1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        step("t5_start0",   0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
        step("t5_ldstart",  0, 1, 16'h0007, 1, 0, 0, 1, 16'h0007, 0, 0, 0, 0);
        step("t6_load50",   0, 1, 16'h0050, 0, 0, 0, 0, 16'h0050, 0, 0, 0, 0);
        step("t6_start",    0, 0, 16'h0000, 1, 0, 0, 0, 16'h0050, 1, 0, 0, 0);
        step("t6_tick",     0, 0, 16'h0000, 0, 0, 0, 1, 16'h0049, 1, 0, 0, 0);
        step("t6_badrun",   0, 1, 16'h00F0, 0, 0, 0, 1, 16'h0049, 1, 0, 0, 1);
        step("t6_rst",      1, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
        step("t6_start0",   0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
        step("t7_load9999", 0, 1, 16'h9999, 0, 0, 0, 0, 16'h9999, 0, 0, 0, 0);
        step("t7_start",    0, 0, 16'h0000, 1, 0, 0, 0, 16'h9999, 1, 0, 0, 0);
        step("t7_tick",     0, 0, 16'h0000, 0, 0, 0, 1, 16'h9998, 1, 0, 0, 0);
        step("t7_notick",   0, 0, 16'h0000, 0, 0, 0, 0, 16'h9998, 1, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
